// File: rtl/rs_decode_sched_pkg.sv
// Shared types and sizing for the RS decoder scheduler.
//   sched_state_e : sequencer states, one job at a time through the shared core
//   RsWordW       : width of one codeword word
//   RsNumWords    : words per codeword / error-position vector
//   RsCwW         : full codeword width
package rs_decode_sched_pkg;

  localparam int RsWordW    = 32;
  localparam int RsNumWords = 50;
  localparam int RsCwW      = RsWordW * RsNumWords;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT_RDY,
    START,
    BUSY,
    RESP
  } sched_state_e;

endpackage

// File: rtl/rs_rr_arbiter.sv
// Round-robin request picker.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted request
//   any   : at least one request present
// Purely combinational; the caller owns and advances the pointer.
module rs_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] at_or_above;
  logic [N-1:0] upper;

  // Requests at index >= ptr form the first search window; if none of
  // them is active the search wraps to the full vector from index 0.
  assign at_or_above = ~((N'(1) << ptr) - N'(1));
  assign upper       = req & at_or_above;
  assign any         = |req;

  always_comb begin
    idx   = '0;
    grant = '0;
    // Downward scan so the lowest active index is the last one written.
    if (|upper) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (upper[i]) idx = IW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) idx = IW'(i);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/rs_decode_sched.sv
// Shares one RS decoder core between NREQ requesters.
// A job is: round-robin accept of one codeword, clear the core, wait for
// core ready, pulse decode enable, wait for output valid (bounded by
// TIMEOUT), then hold the response for the granted requester until taken.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : codeword handshake per requester (ready one-hot, IDLE only)
//   req_data_i               : requester i codeword at [i*CW_W +: CW_W]
//   rsp_valid_o/rsp_ready_i  : response handshake per requester (valid one-hot)
//   rsp_error_pos_o, rsp_with_error_o, rsp_timeout_o : shared response bus
//   dec_clrn_o, dec_en_o, dec_data_o                  : core control / codeword
//   dec_ready_i, dec_valid_i, dec_with_error_i, dec_error_pos_i : core status
//   busy_o                   : a job is in progress
module rs_decode_sched
  import rs_decode_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int NUM_WORDS = RsNumWords,
  parameter int WORD_W    = RsWordW,
  parameter int CLR_CYC   = 2,
  parameter int TIMEOUT   = 4096,
  localparam int CW_W     = NUM_WORDS * WORD_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*CW_W-1:0] req_data_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [CW_W-1:0]      rsp_error_pos_o,
  output logic                 rsp_with_error_o,
  output logic                 rsp_timeout_o,
  output logic                 dec_clrn_o,
  output logic                 dec_en_o,
  output logic [CW_W-1:0]      dec_data_o,
  input  logic                 dec_ready_i,
  input  logic                 dec_valid_i,
  input  logic                 dec_with_error_i,
  input  logic [CW_W-1:0]      dec_error_pos_i,
  output logic                 busy_o
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CCW = $clog2(CLR_CYC + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  sched_state_e    state_reg, state_next;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   gidx_reg;
  logic [CCW-1:0]  clr_cnt_reg;
  logic [TCW-1:0]  tmo_cnt_reg;
  logic [CW_W-1:0] data_reg;
  logic [CW_W-1:0] epos_reg;
  logic            werr_reg;
  logic            tmo_reg;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            clr_done;
  logic            tmo_expired;

  logic [CW_W-1:0] req_words [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_words[gi] = req_data_i[gi*CW_W +: CW_W];
  end

  rs_rr_arbiter #(.N(NREQ)) u_arb (
    .req   (req_valid_i),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign clr_done    = (clr_cnt_reg == CCW'(CLR_CYC - 1));
  assign tmo_expired = (tmo_cnt_reg == TCW'(TIMEOUT - 1));

  always_comb begin
    state_next  = state_reg;
    req_ready_o = '0;
    rsp_valid_o = '0;
    dec_clrn_o  = 1'b1;
    dec_en_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          req_ready_o = arb_grant;
          state_next  = CLEAR;
        end
      end
      CLEAR: begin
        dec_clrn_o = 1'b0;
        if (clr_done) state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (dec_ready_i) state_next = START;
      end
      START: begin
        dec_en_o   = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (dec_valid_i || tmo_expired) state_next = RESP;
      end
      RESP: begin
        rsp_valid_o[gidx_reg] = 1'b1;
        // Only the granted requester's ready completes the handshake.
        if (rsp_ready_i[gidx_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      gidx_reg    <= '0;
      clr_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
      data_reg    <= '0;
      epos_reg    <= '0;
      werr_reg    <= 1'b0;
      tmo_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            data_reg    <= req_words[arb_idx];
            gidx_reg    <= arb_idx;
            ptr_reg     <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            clr_cnt_reg <= '0;
          end
        end
        CLEAR:   clr_cnt_reg <= clr_cnt_reg + 1'b1;
        START:   tmo_cnt_reg <= '0;
        BUSY: begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          // A result arriving on the expiry cycle still counts as a decode.
          if (dec_valid_i) begin
            epos_reg <= dec_error_pos_i;
            werr_reg <= dec_with_error_i;
            tmo_reg  <= 1'b0;
          end else if (tmo_expired) begin
            epos_reg <= '0;
            werr_reg <= 1'b1;
            tmo_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dec_data_o       = data_reg;
  assign rsp_error_pos_o  = epos_reg;
  assign rsp_with_error_o = werr_reg;
  assign rsp_timeout_o    = tmo_reg;
  assign busy_o           = (state_reg != IDLE);

endmodule
